evt2_byte_packer: RTL
=====================

// Module: evt2_byte_packer
// PURPOSE
//   Upstream feeder for the gesture classifier's EVT 2.0 input. Assembles a raw
//   8-bit byte stream (UART/SPI bridge, no backpressure) into 32-bit EVT 2.0
//   words and presents them on a valid/ready interface that connects directly
//   to evt_data/evt_valid/evt_ready. It holds completed words in a 2-entry skid
//   FIFO, drops a partial word after a byte-gap timeout and counts drops.
// PARAMETERS
//   LITTLE_ENDIAN   1     1: first byte -> [7:0]; 0: first byte -> [31:24]
//   TIMEOUT_CYCLES  4096  idle cycles with a partial word before discard (>=2)
//   CNT_BITS        16    width of drop/resync statistics counters
// PORTS
//   clk           in   1         system clock
//   rst_n         in   1         synchronous active-low reset
//   byte_data     in   8         incoming byte
//   byte_valid    in   1         byte strobe; one byte per asserted cycle
//   flush         in   1         sync clear of partial word and FIFO (stats kept)
//   clear_stats   in   1         sync clear of counters and overflow flag
//   evt_data      out  32        head-of-FIFO EVT 2.0 word
//   evt_valid     out  1         FIFO non-empty
//   evt_ready     in   1         consumer accepts evt_data this cycle
//   drop_count    out  CNT_BITS  words lost to full FIFO (saturating)
//   resync_count  out  CNT_BITS  partial words discarded by timeout (saturating)
//   overflow      out  1         sticky: at least one word dropped
//   busy          out  1         partial word pending or FIFO non-empty
// BEHAVIOUR
// - Reset (rst_n==0 at clk edge): byte_idx=0, partial=0, FIFO empty, evt_valid=0,
//   evt_data=0, counters=0, overflow=0, idle timer=0, busy=0. Overrides all inputs.
// - Assembly: byte_idx 0..3 counts bytes. Each byte_valid writes byte_data into
//   lane byte_idx (LE) or 3-byte_idx (BE), then increments byte_idx. On the 4th
//   byte, byte_idx wraps to 0 and {partial,byte} is pushed in the same cycle.
// - Latency: 4th byte sampled at edge N; word visible with evt_valid=1 after
//   edge N when FIFO was empty. This is a single-cycle latency, with no
//   combinational path from byte_* to evt_*.
// - FIFO: 2 entries, registered outputs. evt_data is the head entry and holds
//   0 when empty. Pop happens when evt_valid && evt_ready. Push happens on word
//   completion.
//   * Push on full FIFO with no pop: word discarded, drop_count+1, overflow=1.
//   * Push on full FIFO with a pop in the same cycle: push accepted, no drop.
//   * Push on empty FIFO with evt_ready=1: word is not visible until the next
//     cycle. There is no bypass.
//   * evt_data must not change while evt_valid && !evt_ready.
// - Timeout: the idle timer clears on every byte_valid and whenever byte_idx==0.
//   It increments each cycle with byte_idx!=0 && !byte_valid. When it reaches
//   TIMEOUT_CYCLES: byte_idx=0, partial=0, resync_count+1, timer=0. A byte in
//   the same cycle as expiry wins: it is taken as the next byte and the timer
//   clears.
// - flush: byte_idx=0, partial=0, FIFO emptied, timer=0. A byte_valid in the
//   same cycle is discarded. Pop, drop and resync are suppressed that cycle.
//   Counters and overflow are unchanged.
// - clear_stats: counters=0, overflow=0. If a drop or resync occurs in the same
//   cycle, clear wins (result 0).
// - Counters saturate at 2^CNT_BITS-1 and never wrap.
// - busy = (byte_idx!=0) || evt_valid, from registered state.
// TESTING
// - LE=1: bytes 0x11,0x22,0x33,0x44 on consecutive cycles, evt_ready=1
//   -> evt_data=0x44332211 with evt_valid for exactly 1 cycle, one cycle after
//   the 4th byte.
// - LE=0: same bytes with 5 idle cycles between each -> evt_data=0x11223344.
// - evt_ready=0, send 3 words (12 bytes) -> first two words held in order,
//   third dropped, drop_count=1, overflow=1. Then evt_ready=1 -> exactly 2
//   words emitted.
// - TIMEOUT_CYCLES=8: 2 bytes then 8 idle cycles -> resync_count=1; the next 4
//   bytes 0xA0..0xA3 yield 0xA3A2A1A0. Repeat with a byte on the 8th idle
//   cycle -> no resync.
// - FIFO full, evt_ready=1 on the cycle the 4th byte of a new word arrives
//   -> no drop, FIFO still holds 2 words.
// - flush with 1 word queued and 2 bytes partial -> evt_valid=0 and busy=0 next
//   cycle, counters unchanged. rst_n low mid-word -> all outputs 0, next 4 bytes
//   form a clean word.

Source files
------------

// File: rtl/evt2_byte_packer.sv
// Packs a raw byte stream into 32-bit EVT 2.0 words, queues them in a 2-entry
// registered FIFO and discards stalled partial words after a byte-gap timeout.
module evt2_byte_packer #(
    parameter bit          LITTLE_ENDIAN  = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned CNT_BITS       = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          byte_data,
    input  logic                byte_valid,
    input  logic                flush,
    input  logic                clear_stats,
    output logic [31:0]         evt_data,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [CNT_BITS-1:0] drop_count,
    output logic [CNT_BITS-1:0] resync_count,
    output logic                overflow,
    output logic                busy
);

    localparam int unsigned        TW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]      TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [31:0]         partial_q, partial_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [31:0]         head_q, head_d;
    logic [31:0]         second_q, second_d;
    logic [1:0]          count_q, count_d;
    logic [CNT_BITS-1:0] drop_q, drop_d;
    logic [CNT_BITS-1:0] resync_q, resync_d;
    logic                overflow_q, overflow_d;

    logic [1:0]  lane;
    logic [31:0] assembled;
    logic        push, pop, drop, expire;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        byte_idx_d = byte_idx_q;
        partial_d  = partial_q;
        timer_d    = timer_q;
        head_d     = head_q;
        second_d   = second_q;
        count_d    = count_q;
        drop_d     = drop_q;
        resync_d   = resync_q;
        overflow_d = overflow_q;
        push       = 1'b0;
        pop        = 1'b0;
        drop       = 1'b0;
        expire     = 1'b0;

        lane      = LITTLE_ENDIAN ? byte_idx_q : 2'd3 - byte_idx_q;
        assembled = partial_q;
        assembled[{lane, 3'b000} +: 8] = byte_data;

        if (flush) begin
            byte_idx_d = 2'd0;
            partial_d  = '0;
            timer_d    = '0;
            head_d     = '0;
            second_d   = '0;
            count_d    = 2'd0;
        end else begin
            if (byte_valid) begin
                timer_d    = '0;
                byte_idx_d = byte_idx_q + 2'd1;
                push       = (byte_idx_q == 2'd3);
                partial_d  = push ? '0 : assembled;
            end else if (byte_idx_q != 2'd0) begin
                if (timer_q == TIMER_LAST) begin
                    expire     = 1'b1;
                    byte_idx_d = 2'd0;
                    partial_d  = '0;
                    timer_d    = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end else begin
                timer_d = '0;
            end

            pop = (count_q != 2'd0) && evt_ready;

            // Head is always slot 0 so evt_data comes straight from a register.
            unique case (count_q)
                2'd0: begin
                    if (push) begin
                        head_d  = assembled;
                        count_d = 2'd1;
                    end
                end
                2'd1: begin
                    if (pop && push) begin
                        head_d = assembled;
                    end else if (pop) begin
                        head_d  = '0;
                        count_d = 2'd0;
                    end else if (push) begin
                        second_d = assembled;
                        count_d  = 2'd2;
                    end
                end
                default: begin
                    if (pop) begin
                        head_d   = second_q;
                        second_d = push ? assembled : '0;
                        count_d  = push ? 2'd2 : 2'd1;
                    end else begin
                        drop = push;
                    end
                end
            endcase
        end

        if (clear_stats) begin
            drop_d     = '0;
            resync_d   = '0;
            overflow_d = 1'b0;
        end else begin
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_q != CNT_MAX) drop_d = drop_q + CNT_BITS'(1);
            end
            if (expire && (resync_q != CNT_MAX)) resync_d = resync_q + CNT_BITS'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_idx_q <= 2'd0;
            partial_q  <= '0;
            timer_q    <= '0;
            // NOTE: FIFO storage is reset too, because evt_data must read 0 when empty.
            head_q     <= '0;
            second_q   <= '0;
            count_q    <= 2'd0;
            drop_q     <= '0;
            resync_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            byte_idx_q <= byte_idx_d;
            partial_q  <= partial_d;
            timer_q    <= timer_d;
            head_q     <= head_d;
            second_q   <= second_d;
            count_q    <= count_d;
            drop_q     <= drop_d;
            resync_q   <= resync_d;
            overflow_q <= overflow_d;
        end
    end

    assign evt_data     = head_q;
    assign evt_valid    = (count_q != 2'd0);
    assign busy         = (byte_idx_q != 2'd0) || (count_q != 2'd0);
    assign drop_count   = drop_q;
    assign resync_count = resync_q;
    assign overflow     = overflow_q;

endmodule
